// File: rtl/turn_pkg.sv
// Shared definitions for the turn-signal input conditioner and the tail-light FSM.
// Latency: n/a (constants, types and elaboration helpers only).
// Backpressure: n/a.
package turn_pkg;

  // Mode encodings presented to the tail-light FSM: {right, left}.
  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_HAZARD = 2'b11;

  // Sequencer state type, kept as plain constants so older code can compare raw codes.
  typedef logic [1:0] turn_state_t;
  localparam turn_state_t ST_IDLE  = 2'd0;
  localparam turn_state_t ST_ARMED = 2'd1;
  localparam turn_state_t ST_RUN   = 2'd2;

  // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Both switches on means hazard, which falls out of packing right above left.
  function automatic logic [1:0] pack_req(input logic right_db, input logic left_db);
    return {right_db, left_db};
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: 2-flop synchronizer followed by a consecutive-sample debouncer.
// Latency: a raw change stable from cycle t is visible on db at cycle t+2+DEBOUNCE_CYCLES.
// Backpressure: none; free-running, samples every clk.
module debounce_ch
  import turn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          db_q;

  // Two-stage synchronizer; raw is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count samples that disagree with the accepted value; accept on the Nth in a row.
  // A sample agreeing with db clears the run, and the count clears on acceptance,
  // so it tops out at DEBOUNCE_CYCLES-1 and never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      db_q <= 1'b0;
    end else if (sync2 == db_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db_q <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign db = db_q;

endmodule

// File: rtl/turn_input_conditioner.sv
// Conditions raw turn switches into a latched mode plus step ticks for the tail-light FSM.
// Latency: switch to mode is 2+DEBOUNCE_CYCLES cycles plus wait for the next prescaler tick.
// Backpressure: none; seq_done ends a running sequence, requests during RUN are ignored.
module turn_input_conditioner
  import turn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       seq_done,
  output logic [1:0] mode,
  output logic       step,
  output logic       busy
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          left_db;
  logic          right_db;
  logic [1:0]    req;
  logic [PW-1:0] presc;
  logic          tick;
  turn_state_t   state;
  turn_state_t   state_nxt;
  logic [1:0]    mode_q;
  logic [1:0]    mode_nxt;
  logic          running;

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_left_db (
    .clk   (clk),
    .reset (reset),
    .raw   (left_in),
    .db    (left_db)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_right_db (
    .clk   (clk),
    .reset (reset),
    .raw   (right_in),
    .db    (right_db)
  );

  assign req = pack_req(right_db, left_db);

  // Free-running step prescaler, 0..TICK_DIV-1; restarts from 0 out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == PRESC_LAST);

  // Sequencer: wait for a request, latch it on a tick, hold it until seq_done.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    case (state)
      ST_IDLE: begin
        mode_nxt = MODE_IDLE;
        if (req != MODE_IDLE) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A request that vanishes before the tick is dropped, even if the tick is now.
        if (req == MODE_IDLE) begin
          state_nxt = ST_IDLE;
          mode_nxt  = MODE_IDLE;
        end else if (tick) begin
          state_nxt = ST_RUN;
          mode_nxt  = req;
        end
      end
      ST_RUN: begin
        // Switch changes are ignored here so a sequence always plays to completion.
        if (seq_done) begin
          state_nxt = ST_IDLE;
          mode_nxt  = MODE_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        mode_nxt  = MODE_IDLE;
      end
    endcase
  end

  // Sequencer state and latched mode registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      mode_q <= MODE_IDLE;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Outputs: mode/step only mean something in RUN. seq_done drops both in its own
  // cycle so the FSM never steps on a finished sequence, and an asserted reset
  // suppresses step on the edge that aborts the run.
  always_comb begin
    running = (state == ST_RUN);
    busy    = running;
    mode    = (running && !seq_done) ? mode_q : MODE_IDLE;
    step    = running && tick && !seq_done && reset;
  end

endmodule

// File: doc/turn_input_conditioner.md
TURN_INPUT_CONDITIONER -- requirements
Module: turn_input_conditioner

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a switch change (>=2).
REQ-002 SHALL have parameter: TICK_DIV, 8, clk cycles per step tick (>=2).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port: left_in  input  1  raw, asynchronous left turn switch.
REQ-006 SHALL have port: right_in  input  1  raw, asynchronous right turn switch.
REQ-007 SHALL have port: seq_done  input  1  one-cycle pulse from the downstream tail-light FSM when its sequence returns to the off state.
REQ-008 SHALL have port: mode  output  2  latched request to the FSM: 00 idle, 01 left, 10 right, 11 hazard.
REQ-009 SHALL have port: step  output  1  one-cycle enable; the FSM advances one state per pulse.
REQ-010 SHALL have port: busy  output  1  high while a sequence is running.

Function
REQ-011 SHALL pass each raw input through a 2-flop synchronizer before any other use.
REQ-012 SHALL debounce each channel independently: the debounced value takes the synchronized value after DEBOUNCE_CYCLES consecutive equal samples; any differing sample restarts the count; raw change stable from cycle t appears debounced at cycle t+2+DEBOUNCE_CYCLES.
REQ-013 SHALL derive req = {right_db, left_db}, so both channels active encodes hazard (11).
REQ-014 SHALL run a free-running prescaler counting 0..TICK_DIV-1 and wrapping to 0; tick is high exactly on the cycle count==TICK_DIV-1.
REQ-015 SHALL implement an FSM with states IDLE, ARMED, RUN.
REQ-016 IDLE: mode=00, busy=0; go to ARMED when req!=00.
REQ-017 ARMED: on tick, capture req into mode and go to RUN; if req returns to 00 before a tick, go back to IDLE with mode=00.
REQ-018 RUN: busy=1; step=tick; mode frozen; req changes ignored.
REQ-019 RUN with seq_done: mode=00, step=0 in that cycle, go to IDLE; a still-active req rearms from IDLE on the following cycle.
REQ-020 step SHALL be 0 in IDLE and ARMED, so the FSM never advances without a valid mode.
REQ-021 Releasing switches during RUN SHALL NOT truncate the sequence; it completes until seq_done.
REQ-022 seq_done outside RUN SHALL be ignored.
REQ-023 seq_done coinciding with tick in RUN: seq_done wins and step=0.
REQ-024 Debounce counters SHALL saturate at DEBOUNCE_CYCLES-1 and never wrap.

Reset
REQ-025 With reset=0 at a clk edge: synchronizers and debounced values 0, debounce counters 0, prescaler 0, state IDLE, mode=00, step=0, busy=0.
REQ-026 Reset mid-sequence SHALL abort RUN immediately; no step is issued on the reset edge or the cycle after.

Structure
REQ-027 A shared package turn_pkg SHALL hold the mode encodings (MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZARD) and the IDLE/ARMED/RUN state type, for use by both this block and the downstream FSM.
REQ-028 A sub-module debounce_ch (synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per channel.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-029 left_in 0->1 held -> mode=01 and busy=1 on the first tick at or after cycle 6, then step pulses every 8 cycles.
REQ-030 left_in glitching 1 for 3 cycles -> mode stays 00, step never asserted.
REQ-031 left_in and right_in raised 1 cycle apart, both held -> mode=11 (hazard).
REQ-032 In RUN with mode=01, right_in asserted and left_in released -> mode stays 01 until seq_done; 1 cycle later IDLE, then mode=10 on the next tick.
REQ-033 reset=0 asserted for 1 cycle in RUN -> next cycle mode=00, busy=0, step=0, prescaler restarts at 0.
REQ-034 seq_done and tick in the same RUN cycle -> step=0, mode=00 that cycle.
